pixel_merge_fifo: RTL

PIXEL_MERGE_FIFO -- requirements
Module: pixel_merge_fifo

---
 rtl/pixel_fifo_pkg.sv | 14 +
 rtl/rr_multi_grant.sv | 41 ++++
 rtl/pixel_merge_fifo.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pixel_fifo_pkg.sv
// Shared types and default sizing for the pixel merge FIFO.
package pixel_fifo_pkg;

    localparam int DEF_DATA_WIDTH  = 20;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_NUM_ENGINES = 5;

    // One pixel word: screen x coordinate and depth value.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] depth;
    } pixel_word_t;

endpackage

// File: rtl/rr_multi_grant.sv
// Rotating multi-grant arbiter: grants up to 'free' requesters per cycle,
// scanning engines in rotation order starting at rr_ptr.
module rr_multi_grant #(
    parameter int NUM_ENGINES = 5,
    parameter int FREE_W      = 7,
    localparam int PTR_W      = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1,
    localparam int CNT_W      = $clog2(NUM_ENGINES + 1)
) (
    input  logic [NUM_ENGINES-1:0] req,
    input  logic [PTR_W-1:0]       rr_ptr,
    input  logic [FREE_W-1:0]      free,
    output logic [NUM_ENGINES-1:0] grant,
    output logic [CNT_W-1:0]       grant_count,
    output logic [PTR_W-1:0]       next_rr_ptr
);

    // Walk engines from rr_ptr, granting requesters until free space runs out.
    always_comb begin
        int   idx;
        int   cnt;
        int   last;
        logic any;
        grant = '0;
        cnt   = 0;
        last  = 0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_ENGINES;
            if (req[idx] && (cnt < int'(free))) begin
                grant[idx] = 1'b1;
                cnt        = cnt + 1;
                last       = idx;
                any        = 1'b1;
            end
        end
        grant_count = CNT_W'(cnt);
        next_rr_ptr = any ? PTR_W'((last + 1) % NUM_ENGINES) : rr_ptr;
    end

endmodule

// File: rtl/pixel_merge_fifo.sv
// Multi-writer, single-reader first-word-fall-through pixel FIFO.
// Several engines may push in the same cycle; granted words are stored at
// consecutive addresses in rotation order. Optional statistics (high-water
// mark, stall cycle counter) are built when PIXEL_FIFO_STATS_EN is defined.
module pixel_merge_fifo
    import pixel_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int NUM_ENGINES  = DEF_NUM_ENGINES,
    parameter int AFULL_THRESH = DEPTH - NUM_ENGINES,
    localparam int LVL_W       = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_ENGINES-1:0]            wr_valid,
    input  logic [DATA_WIDTH*NUM_ENGINES-1:0] wr_data,
    output logic [NUM_ENGINES-1:0]            wr_ready,
    output logic                              rd_valid,
    output logic [DATA_WIDTH-1:0]             rd_data,
    input  logic                              rd_ready,
    output logic [LVL_W-1:0]                  level,
    output logic                              almost_full,
    output logic [LVL_W-1:0]                  max_level,
    output logic [31:0]                       stall_cycles
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int CNT_W = $clog2(NUM_ENGINES + 1);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [PTR_W-1:0]       rr_ptr;
    logic [LVL_W-1:0]       level_q;
    logic [LVL_W-1:0]       level_next;
    logic [LVL_W-1:0]       free;
    logic [NUM_ENGINES-1:0] grant;
    logic [CNT_W-1:0]       grant_count;
    logic [PTR_W-1:0]       next_rr_ptr;
    logic [AW-1:0]          waddr [NUM_ENGINES];
    logic                   pop;

    // Free space comes from registered level only, so a same-cycle pop
    // never opens room for writes and wr_ready is independent of rd_ready.
    assign free = LVL_W'(DEPTH) - level_q;

    rr_multi_grant #(
        .NUM_ENGINES (NUM_ENGINES),
        .FREE_W      (LVL_W)
    ) u_grant (
        .req         (wr_valid),
        .rr_ptr      (rr_ptr),
        .free        (free),
        .grant       (grant),
        .grant_count (grant_count),
        .next_rr_ptr (next_rr_ptr)
    );

    assign wr_ready    = grant;
    assign rd_valid    = (level_q != '0);
    assign rd_data     = mem[rd_ptr];
    assign level       = level_q;
    assign almost_full = (int'(level_q) >= AFULL_THRESH);
    assign pop         = rd_valid && rd_ready;
    assign level_next  = level_q + LVL_W'(grant_count) - LVL_W'(pop);

    // Each granted engine takes the next address after the grants ahead of it in rotation order.
    always_comb begin
        int            idx;
        logic [AW-1:0] off;
        off = '0;
        idx = 0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            waddr[i] = '0;
        end
        for (int k = 0; k < NUM_ENGINES; k++) begin
            idx        = (int'(rr_ptr) + k) % NUM_ENGINES;
            waddr[idx] = wr_ptr + off;
            if (grant[idx]) begin
                off = off + AW'(1);
            end
        end
    end

    // Store granted words; storage itself is never cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (grant[i] && !reset) begin
                mem[waddr[i]] <= wr_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Pointer and occupancy bookkeeping; reset discards everything stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rr_ptr  <= '0;
            level_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(grant_count);
            rd_ptr  <= rd_ptr + AW'(pop);
            rr_ptr  <= next_rr_ptr;
            level_q <= level_next;
        end
    end

`ifdef PIXEL_FIFO_STATS_EN
    logic [LVL_W-1:0] max_q;
    logic [31:0]      stall_q;

    // High-water mark of occupancy and saturating count of cycles with any refused request.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_q   <= '0;
            stall_q <= '0;
        end else begin
            if (level_next > max_q) begin
                max_q <= level_next;
            end
            if (((wr_valid & ~grant) != '0) && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign max_level    = max_q;
    assign stall_cycles = stall_q;
`else
    assign max_level    = '0;
    assign stall_cycles = '0;
`endif

endmodule
